// File: rtl/sap_core_pkg.sv
// Shared definitions for the SAP core: opcode and sequencer state encodings,
// plus a decode helper used by the FSM.
package sap_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_HALT
  } state_t;

  // Instructions that need a second RAM access through MAR in T3.
  function automatic logic uses_mem(input opcode_t op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/sap_core_alu.sv
// Combinational adder/subtractor for the SAP accumulator path.
// Subtraction is A + ~B + 1, so carry=1 means "no borrow".
module sap_core_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   full;

  assign b_eff   = sub_i ? ~b_i : b_i;
  assign full    = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};
  assign sum_o   = full[DATA_W-1:0];
  assign carry_o = full[DATA_W];
  assign zero_o  = (full[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_core.sv
// Hardwired-control SAP accumulator CPU: T0..T4 sequencer, inline RAM with an
// external load port, run/stall control and a strobed OUT register.
module sap_core
  import sap_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] out_value,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d, out_q, out_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic              carry_q, carry_d, zero_q, zero_d;
  logic              out_valid_q, out_valid_d, halted_q, halted_d;
  logic              core_we, load_ok;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [DATA_W-1:0] ram_rd;

  opcode_t           opcode;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] alu_sum;
  logic              alu_carry, alu_zero;

  assign ram_rd = ram_q[mar_q];
  assign opcode = opcode_t'(ir_q[DATA_W-1 -: 4]);
  assign opnd   = ir_q[ADDR_W-1:0];

  sap_core_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .sub_i  (opcode == OP_SUB),
    .sum_o  (alu_sum),
    .carry_o(alu_carry),
    .zero_o (alu_zero)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_d        = ir_q;
    out_d       = out_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    halted_d    = halted_q;
    out_valid_d = 1'b0;
    core_we     = 1'b0;

    if (run) begin
      case (state_q)
        S_T0: begin
          mar_d   = pc_q;
          state_d = S_T1;
        end
        S_T1: begin
          ir_d    = ram_rd;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_T2;
        end
        S_T2: begin
          state_d = S_T0;
          if (uses_mem(opcode)) begin
            mar_d   = opnd;
            state_d = S_T3;
          end else begin
            case (opcode)
              OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, opnd};
              OP_JMP: pc_d = opnd;
              OP_JC:  if (carry_q) pc_d = opnd;
              OP_JZ:  if (zero_q) pc_d = opnd;
              OP_OUT: begin
                out_d       = a_q;
                out_valid_d = 1'b1;
              end
              OP_HLT: begin
                halted_d = 1'b1;
                state_d  = S_HALT;
              end
              default: ;
            endcase
          end
        end
        S_T3: begin
          state_d = S_T0;
          case (opcode)
            OP_LDA: a_d = ram_rd;
            OP_ADD, OP_SUB: begin
              b_d     = ram_rd;
              state_d = S_T4;
            end
            OP_STA: core_we = 1'b1;
            default: ;
          endcase
        end
        S_T4: begin
          a_d     = alu_sum;
          carry_d = alu_carry;
          zero_d  = alu_zero;
          state_d = S_T0;
        end
        S_HALT: ;
        default: state_d = S_T0;
      endcase
    end
  end

  // NOTE: clocked blocks use <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_T0;
      a_q         <= '0;
      b_q         <= '0;
      ir_q        <= '0;
      out_q       <= '0;
      pc_q        <= '0;
      mar_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ir_q        <= ir_d;
      out_q       <= out_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  // Loader and core never both write: the loader only wins while stalled or halted.
  assign load_ok = load_en && (!run || halted_q);

  // NOTE: RAM is intentionally not reset, so programs survive reset_n.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      ram_q[load_addr] <= load_data;
    end else if (core_we) begin
      ram_q[mar_q] <= a_q;
    end
  end

  assign out_value = out_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_sap_core.sv
// Self-checking bench for sap_core: programs are loaded through the load port,
// expected OUT values go to a scoreboard and are matched on each out_valid pulse.
module tb_sap_core;
  import sap_core_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] out_value;
  logic       out_valid;
  logic       halted;
  logic [3:0] pc;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  logic [7:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic saw_wrap;

  sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .out_value(out_value),
    .out_valid(out_valid),
    .halted   (halted),
    .pc       (pc)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      pulses++;
      n_checks++;
      if (prev_valid) $display("FAIL out_valid_double: high two cycles in a row");
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_unexpected: got %h with empty scoreboard", out_value);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_value !== e) $display("FAIL out_value: got %h want %h", out_value, e);
        else n_pass++;
      end
    end
    prev_valid = (reset_n === 1'b1) && (out_valid === 1'b1);
  end

  function automatic logic [7:0] ins(input opcode_t op, input logic [3:0] a);
    return {op, a};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    run     = 1'b0;
    load_en = 1'b0;
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step(1);
    load_en   = 1'b0;
  endtask

  task automatic run_until_halt(input int max_cycles, output int cycles);
    logic [3:0] prev_pc;
    cycles   = 0;
    saw_wrap = 1'b0;
    run      = 1'b1;
    while (!halted && cycles < max_cycles) begin
      prev_pc = pc;
      step(1);
      cycles++;
      if (prev_pc == 4'd15 && pc == 4'd0) saw_wrap = 1'b1;
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d outputs never appeared", name, exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    load_en = 1'b0;
    #2;
    n_checks++; if (out_value !== 8'h00) $display("FAIL rst_out_value: got %h want 00", out_value); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if (pc !== 4'd0) $display("FAIL rst_pc: got %0d want 0", pc); else n_pass++;
    step(1);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) load_word(4'(i), 8'h00);
  endtask

  task automatic load_add_prog();
    load_word(4'd0, ins(OP_LDI, 4'd5));
    load_word(4'd1, ins(OP_ADD, 4'd14));
    load_word(4'd2, ins(OP_OUT, 4'd0));
    load_word(4'd3, ins(OP_HLT, 4'd0));
    load_word(4'd14, 8'd3);
  endtask

  task automatic test_add_out();
    int cyc, p0;
    load_add_prog();
    do_reset();
    exp_q.push_back(8'(5 + 3));
    p0 = pulses;
    run_until_halt(60, cyc);
    step(2);
    run = 1'b0;
    n_checks++; if (cyc !== 3 + 5 + 3 + 3) $display("FAIL add_cycles: got %0d want 14", cyc); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL add_halted: got %b want 1", halted); else n_pass++;
    n_checks++; if (pulses - p0 !== 1) $display("FAIL add_pulses: got %0d want 1", pulses - p0); else n_pass++;
    n_checks++; if (pc !== 4'd4) $display("FAIL add_pc: got %0d want 4", pc); else n_pass++;
    check_drained("add");
  endtask

  task automatic test_sub_flags();
    int cyc;
    // 7-7 sets zero and carry, so JZ 6 lands on OUT(0), HLT.
    load_word(4'd0, ins(OP_LDA, 4'd10));
    load_word(4'd1, ins(OP_SUB, 4'd11));
    load_word(4'd2, ins(OP_JZ, 4'd6));
    load_word(4'd3, ins(OP_HLT, 4'd0));
    load_word(4'd6, ins(OP_OUT, 4'd0));
    load_word(4'd7, ins(OP_HLT, 4'd0));
    load_word(4'd10, 8'd7);
    load_word(4'd11, 8'd7);
    do_reset();
    exp_q.push_back(8'h00);
    run_until_halt(60, cyc);
    step(1);
    run = 1'b0;
    n_checks++; if (dut.zero_q !== 1'b1) $display("FAIL jz_zero: got %b want 1", dut.zero_q); else n_pass++;
    n_checks++; if (dut.carry_q !== 1'b1) $display("FAIL jz_carry: got %b want 1", dut.carry_q); else n_pass++;
    n_checks++; if (pc !== 4'd8) $display("FAIL jz_pc: got %0d want 8", pc); else n_pass++;
    check_drained("jz");

    // 3-5 borrows: carry=0, so JC 5 falls through to OUT(FE), HLT at 4.
    load_word(4'd0, ins(OP_LDI, 4'd3));
    load_word(4'd1, ins(OP_SUB, 4'd10));
    load_word(4'd2, ins(OP_JC, 4'd5));
    load_word(4'd3, ins(OP_OUT, 4'd0));
    load_word(4'd4, ins(OP_HLT, 4'd0));
    load_word(4'd5, ins(OP_HLT, 4'd0));
    load_word(4'd10, 8'd5);
    do_reset();
    exp_q.push_back(8'(3 - 5));
    run_until_halt(60, cyc);
    step(1);
    run = 1'b0;
    n_checks++; if (dut.a_q !== 8'hFE) $display("FAIL jc_a: got %h want fe", dut.a_q); else n_pass++;
    n_checks++; if (dut.carry_q !== 1'b0) $display("FAIL jc_carry: got %b want 0", dut.carry_q); else n_pass++;
    n_checks++; if (dut.zero_q !== 1'b0) $display("FAIL jc_zero: got %b want 0", dut.zero_q); else n_pass++;
    n_checks++; if (pc !== 4'd5) $display("FAIL jc_pc: got %0d want 5", pc); else n_pass++;
    check_drained("jc");
  endtask

  task automatic test_sta_lda();
    int cyc;
    load_word(4'd0, ins(OP_LDA, 4'd13));
    load_word(4'd1, ins(OP_STA, 4'd15));
    load_word(4'd2, ins(OP_LDI, 4'd0));
    load_word(4'd3, ins(OP_LDA, 4'd15));
    load_word(4'd4, ins(OP_OUT, 4'd0));
    load_word(4'd5, ins(OP_HLT, 4'd0));
    load_word(4'd13, 8'h2A);
    load_word(4'd15, 8'h00);
    do_reset();
    exp_q.push_back(8'h2A);
    run_until_halt(60, cyc);
    step(1);
    run = 1'b0;
    n_checks++; if (cyc !== 4 + 4 + 3 + 4 + 3 + 3) $display("FAIL sta_cycles: got %0d want 21", cyc); else n_pass++;
    n_checks++; if (dut.ram_q[15] !== 8'h2A) $display("FAIL sta_ram: got %h want 2a", dut.ram_q[15]); else n_pass++;
    check_drained("sta");
  endtask

  task automatic test_pc_wrap();
    int cyc;
    // Self-modifying: store HLT into word 0, then JMP 15 -> NOP -> wrap to 0.
    load_word(4'd0, ins(OP_LDA, 4'd13));
    load_word(4'd1, ins(OP_STA, 4'd0));
    load_word(4'd2, ins(OP_JMP, 4'd15));
    load_word(4'd13, ins(OP_HLT, 4'd0));
    load_word(4'd15, ins(OP_NOP, 4'd0));
    do_reset();
    run_until_halt(60, cyc);
    run = 1'b0;
    n_checks++; if (saw_wrap !== 1'b1) $display("FAIL wrap_seen: got %b want 1", saw_wrap); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL wrap_halted: got %b want 1", halted); else n_pass++;
    n_checks++; if (pc !== 4'd1) $display("FAIL wrap_pc: got %0d want 1", pc); else n_pass++;
    n_checks++; if (cyc !== 17) $display("FAIL wrap_cycles: got %0d want 17", cyc); else n_pass++;
  endtask

  task automatic test_stall();
    int cyc;
    load_add_prog();
    do_reset();
    exp_q.push_back(8'd8);
    run = 1'b1;
    step(6);
    run = 1'b0;
    step(10);
    n_checks++; if (dut.state_q !== S_T3) $display("FAIL stall_state: got %0d want %0d", dut.state_q, S_T3); else n_pass++;
    n_checks++; if (pc !== 4'd2) $display("FAIL stall_pc: got %0d want 2", pc); else n_pass++;
    n_checks++; if (dut.a_q !== 8'd5) $display("FAIL stall_a: got %h want 05", dut.a_q); else n_pass++;
    n_checks++; if (dut.b_q !== 8'd0) $display("FAIL stall_b: got %h want 00", dut.b_q); else n_pass++;
    n_checks++; if (dut.mar_q !== 4'd14) $display("FAIL stall_mar: got %0d want 14", dut.mar_q); else n_pass++;
    n_checks++; if (dut.ir_q !== 8'h2E) $display("FAIL stall_ir: got %h want 2e", dut.ir_q); else n_pass++;
    run_until_halt(60, cyc);
    step(1);
    run = 1'b0;
    n_checks++; if (cyc !== 8) $display("FAIL stall_rest_cycles: got %0d want 8", cyc); else n_pass++;
    check_drained("stall");
  endtask

  task automatic test_reset_mid_sta();
    load_word(4'd0, ins(OP_LDI, 4'd9));
    load_word(4'd1, ins(OP_STA, 4'd12));
    load_word(4'd2, ins(OP_HLT, 4'd0));
    load_word(4'd12, 8'h33);
    do_reset();
    run = 1'b1;
    step(6);
    reset_n = 1'b0;
    #1;
    n_checks++; if (pc !== 4'd0) $display("FAIL rmid_pc: got %0d want 0", pc); else n_pass++;
    n_checks++; if (dut.a_q !== 8'h00) $display("FAIL rmid_a: got %h want 00", dut.a_q); else n_pass++;
    n_checks++; if (out_value !== 8'h00 || out_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL rmid_outs: got %h/%b/%b want 00/0/0", out_value, out_valid, halted);
    else n_pass++;
    step(2);
    n_checks++; if (dut.ram_q[12] !== 8'h33) $display("FAIL rmid_ram: got %h want 33", dut.ram_q[12]); else n_pass++;
    run = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_load_gating();
    int cyc;
    for (int i = 0; i < 4; i++) load_word(4'(i), ins(OP_NOP, 4'd0));
    load_word(4'd4, ins(OP_HLT, 4'd0));
    load_word(4'd9, 8'h11);
    do_reset();
    run = 1'b1;
    step(2);
    load_word(4'd9, 8'h77);
    n_checks++; if (dut.ram_q[9] !== 8'h11) $display("FAIL load_running: got %h want 11", dut.ram_q[9]); else n_pass++;
    run_until_halt(60, cyc);
    n_checks++; if (halted !== 1'b1) $display("FAIL load_halted: got %b want 1", halted); else n_pass++;
    load_word(4'd9, 8'h5A);
    step(3);
    n_checks++; if (dut.ram_q[9] !== 8'h5A) $display("FAIL load_when_halted: got %h want 5a", dut.ram_q[9]); else n_pass++;
    n_checks++; if (pc !== 4'd5) $display("FAIL halt_absorbing_pc: got %0d want 5", pc); else n_pass++;
    run = 1'b0;
  endtask

  initial begin
    load_addr = '0;
    load_data = '0;
    test_reset();
    test_add_out();
    test_sub_flags();
    test_sta_lda();
    test_pc_wrap();
    test_stall();
    test_reset_mid_sta();
    test_load_gating();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
